// File: rtl/axi_ifetch_refill_pkg.sv
// Shared constants and state encoding for the icache AXI refill master.
// Imported by axi_ifetch_refill.
package axi_ifetch_refill_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] ICACHE_AXI_ID  = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RESP = 2'd3
    } refill_state_e;

endpackage

// File: rtl/axi_ifetch_refill.sv
// AXI4 read-only burst master: one INCR burst per icache line refill,
// beats assembled into a line buffer and returned with a sticky error.
module axi_ifetch_refill
    import axi_ifetch_refill_pkg::*;
#(
    parameter int         DATA_WIDTH = 64,
    parameter int         ADDR_WIDTH = 64,
    parameter int         USER_WIDTH = 1024,
    parameter int         BEATS      = 4,
    parameter logic [3:0] AXI_ID     = ICACHE_AXI_ID
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDR_WIDTH-1:0]       req_addr,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [BEATS*DATA_WIDTH-1:0] resp_line,
    output logic                        resp_err,
    output logic [ADDR_WIDTH-1:0]       M_AXI_ARADDR,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    output logic [7:0]                  M_AXI_ARLEN,
    output logic [3:0]                  M_AXI_ARID,
    output logic [2:0]                  M_AXI_ARSIZE,
    output logic [1:0]                  M_AXI_ARBURST,
    output logic                        M_AXI_ARLOCK,
    output logic [3:0]                  M_AXI_ARCACHE,
    output logic [2:0]                  M_AXI_ARPROT,
    output logic [3:0]                  M_AXI_ARQOS,
    output logic [3:0]                  M_AXI_ARREGION,
    output logic [USER_WIDTH-1:0]       M_AXI_ARUSER,
    input  logic [DATA_WIDTH-1:0]       M_AXI_RDATA,
    input  logic                        M_AXI_RLAST,
    input  logic                        M_AXI_RVALID,
    input  logic [3:0]                  M_AXI_RID,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic [USER_WIDTH-1:0]       M_AXI_RUSER,
    output logic                        M_AXI_RREADY
);

    localparam int OFF_BITS = $clog2(BEATS * DATA_WIDTH / 8);
    localparam int CNT_W    = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
        (ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1);

    refill_state_e state_q, state_d;

    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] line_q [BEATS];
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  err_q;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  resp_valid_q, resp_valid_d;

    logic req_fire, ar_fire, rid_ok;
    logic beat_fire, beat_last, beat_early;
    logic unused_ruser;

    assign req_ready  = (state_q == ST_IDLE);
    assign req_fire   = req_valid & req_ready;
    assign ar_fire    = arvalid_q & M_AXI_ARREADY;
    assign rid_ok     = (M_AXI_RID == AXI_ID);

    // Beats for other IDs are refused in the same cycle they appear.
    assign M_AXI_RREADY = rready_q & rid_ok;

    assign beat_fire  = M_AXI_RVALID & M_AXI_RREADY;
    assign beat_last  = beat_fire & (cnt_q == LAST_IDX);
    assign beat_early = beat_fire & M_AXI_RLAST & (cnt_q != LAST_IDX);

    assign unused_ruser = ^M_AXI_RUSER;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_fire)               state_d = ST_AR;
            ST_AR:   if (ar_fire)                state_d = ST_RD;
            ST_RD:   if (beat_last | beat_early) state_d = ST_RESP;
            ST_RESP: if (resp_ready)             state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        arvalid_d    = (state_d == ST_AR);
        rready_d     = (state_d == ST_RD);
        resp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Slots not reached by a short burst keep their old contents.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < BEATS; i++) line_q[i] <= '0;
        end else begin
            if (req_fire) begin
                addr_q <= req_addr & ~OFF_MASK;
                cnt_q  <= '0;
                err_q  <= 1'b0;
            end
            if (beat_fire) begin
                line_q[cnt_q] <= M_AXI_RDATA;
                cnt_q         <= cnt_q + CNT_W'(1);
                if ((M_AXI_RRESP != AXI_RESP_OKAY) | beat_early
                    | (beat_last & ~M_AXI_RLAST))
                    err_q <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < BEATS; g++) begin : g_line
        assign resp_line[g*DATA_WIDTH +: DATA_WIDTH] = line_q[g];
    end

    assign resp_valid     = resp_valid_q;
    assign resp_err       = err_q;
    assign M_AXI_ARVALID  = arvalid_q;
    assign M_AXI_ARADDR   = addr_q;
    assign M_AXI_ARLEN    = 8'(BEATS - 1);
    assign M_AXI_ARSIZE   = 3'($clog2(DATA_WIDTH / 8));
    assign M_AXI_ARBURST  = AXI_BURST_INCR;
    assign M_AXI_ARID     = AXI_ID;
    assign M_AXI_ARLOCK   = 1'b0;
    assign M_AXI_ARCACHE  = '0;
    assign M_AXI_ARPROT   = '0;
    assign M_AXI_ARQOS    = '0;
    assign M_AXI_ARREGION = '0;
    assign M_AXI_ARUSER   = '0;

endmodule

// File: tb/tb_axi_ifetch_refill.sv
// Randomized bench for axi_ifetch_refill against a line/error model
// built from the refill rules.
module tb_axi_ifetch_refill;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int UW = 1024;
    localparam int NB = 4;
    localparam int LW = NB * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_addr;
    logic          resp_valid, resp_ready;
    logic [LW-1:0] resp_line;
    logic          resp_err;
    logic [AW-1:0] araddr;
    logic          arvalid, arready;
    logic [7:0]    arlen;
    logic [3:0]    arid;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arlock;
    logic [3:0]    arcache, arqos, arregion;
    logic [2:0]    arprot;
    logic [UW-1:0] aruser;
    logic [DW-1:0] rdata;
    logic          rlast, rvalid, rready;
    logic [3:0]    rid;
    logic [1:0]    rresp;
    logic [UW-1:0] ruser;

    axi_ifetch_refill dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_line(resp_line), .resp_err(resp_err),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready), .M_AXI_ARLEN(arlen),
        .M_AXI_ARID(arid), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock),
        .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot),
        .M_AXI_ARQOS(arqos), .M_AXI_ARREGION(arregion),
        .M_AXI_ARUSER(aruser),
        .M_AXI_RDATA(rdata), .M_AXI_RLAST(rlast),
        .M_AXI_RVALID(rvalid), .M_AXI_RID(rid),
        .M_AXI_RRESP(rresp), .M_AXI_RUSER(ruser),
        .M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    // Reference model: the line buffer as the icache would see it.
    logic [DW-1:0] mline [NB];

    int ar_delay, early, bad_resp, resp_delay, max_gap;
    bit drop_last, bad_id, fixed_data;

    task automatic check(input string tag, input logic [LW-1:0] got,
                         input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] mflat();
        logic [LW-1:0] r;
        for (int i = 0; i < NB; i++) r[i*DW +: DW] = mline[i];
        return r;
    endfunction

    task automatic cyc_edge();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic r_idle();
        rvalid = 1'b0;
        rid    = 4'd0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        rdata  = '0;
    endtask

    task automatic cfg_plain();
        ar_delay = 0; early = -1; bad_resp = -1; resp_delay = 0;
        max_gap = 0; drop_last = 0; bad_id = 0; fixed_data = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_arvalid"}, arvalid, 0);
        check({tag, "_rready"}, rready, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_err"}, resp_err, 0);
        check({tag, "_resp_line"}, resp_line, 0);
    endtask

    // Start a request and complete the address phase.
    task automatic issue(input logic [AW-1:0] addr);
        logic [AW-1:0] exp_addr;
        exp_addr = addr & ~AW'(NB * DW / 8 - 1);
        cyc = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        #1 check("req_ready_idle", req_ready, 1);
        cyc_edge();
        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
        #1;
        check("arvalid", arvalid, 1);
        check("araddr", araddr, exp_addr);
        check("arlen", arlen, NB - 1);
        check("arsize", arsize, 3);
        check("arburst", arburst, 1);
        check("arid", arid, 0);
        check("ar_misc",
              {arlock, arcache, arprot, arqos, arregion, |aruser}, 0);
        check("req_ready_busy", req_ready, 0);
        for (int i = 0; i < ar_delay; i++) begin
            arready = 1'b0;
            cyc_edge();
            #1;
            check("arvalid_hold", arvalid, 1);
            check("araddr_hold", araddr, exp_addr);
        end
        arready = 1'b1;
        cyc_edge();
        arready = 1'b0;
    endtask

    task automatic txn(input logic [AW-1:0] addr);
        int            extra, nb, gap;
        bit            merr, last;
        logic [DW-1:0] d;
        logic [LW-1:0] line_snap;
        extra = 0;
        merr  = 0;
        nb    = (early >= 0) ? early + 1 : NB;
        issue(addr);
        for (int k = 0; k < nb; k++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                r_idle();
                #1 check("rready_gap", rready, 1);
                cyc_edge();
                extra++;
            end
            if (bad_id && k == 1) begin
                rvalid = 1'b1;
                rid    = 4'h5;
                rdata  = {$urandom, $urandom};
                rlast  = 1'b1;
                rresp  = 2'b10;
                #1 check("rready_bad_id", rready, 0);
                cyc_edge();
                extra++;
            end
            d = fixed_data ? DW'((k + 1) * 'h11) : {$urandom, $urandom};
            last = (k == early) || (k == NB - 1 && !drop_last);
            rvalid = 1'b1;
            rid    = 4'd0;
            rdata  = d;
            rresp  = (k == bad_resp) ? 2'b10 : 2'b00;
            rlast  = last;
            #1;
            check("rready_beat", rready, 1);
            check("resp_valid_busy", resp_valid, 0);
            cyc_edge();
            mline[k] = d;
            if (k == bad_resp) merr = 1;
            if (k == early && k < NB - 1) merr = 1;
            if (k == NB - 1 && !last) merr = 1;
        end
        r_idle();
        #1;
        check("resp_latency", cyc, 2 + ar_delay + extra + nb);
        check("resp_valid", resp_valid, 1);
        check("resp_line", resp_line, mflat());
        check("resp_err", resp_err, merr);
        check("req_ready_resp", req_ready, 0);
        line_snap = mflat();
        for (int i = 0; i < resp_delay; i++) begin
            resp_ready = 1'b0;
            cyc_edge();
            #1;
            check("resp_valid_hold", resp_valid, 1);
            check("resp_line_hold", resp_line, line_snap);
            check("resp_err_hold", resp_err, merr);
            check("req_ready_hold", req_ready, 0);
        end
        resp_ready = 1'b1;
        cyc_edge();
        resp_ready = 1'b0;
        #1;
        check("resp_valid_drop", resp_valid, 0);
        check("req_ready_back", req_ready, 1);
    endtask

    task automatic reset_mid_burst(input logic [AW-1:0] addr);
        cfg_plain();
        issue(addr);
        for (int k = 0; k < 2; k++) begin
            rvalid = 1'b1;
            rid    = 4'd0;
            rdata  = {$urandom, $urandom};
            rresp  = 2'b10;
            rlast  = 1'b0;
            cyc_edge();
        end
        r_idle();
        #2 rst_n = 1'b0;
        for (int i = 0; i < NB; i++) mline[i] = '0;
        #1 check_reset_outputs("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;
        arready    = 1'b0;
        ruser      = '0;
        r_idle();
        for (int i = 0; i < NB; i++) mline[i] = '0;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        cfg_plain();
        fixed_data = 1;
        txn(64'h8000_0018);

        cfg_plain();
        ar_delay = 5;
        max_gap  = 2;
        txn({$urandom, $urandom});

        cfg_plain();
        bad_resp = 1;
        txn({$urandom, $urandom});

        cfg_plain();
        early = 1;
        txn({$urandom, $urandom});

        cfg_plain();
        drop_last = 1;
        txn({$urandom, $urandom});

        cfg_plain();
        resp_delay = 3;
        txn({$urandom, $urandom});

        cfg_plain();
        bad_id = 1;
        txn({$urandom, $urandom});

        reset_mid_burst(64'h0000_1234_5678_9abc);
        cfg_plain();
        txn({$urandom, $urandom});

        for (int t = 0; t < 30; t++) begin
            cfg_plain();
            ar_delay   = $urandom_range(3, 0);
            max_gap    = $urandom_range(2, 0);
            resp_delay = $urandom_range(2, 0);
            if ($urandom_range(3, 0) == 0) early = $urandom_range(2, 0);
            if ($urandom_range(3, 0) == 0) bad_resp = $urandom_range(NB - 1, 0);
            if (early < 0 && $urandom_range(5, 0) == 0) drop_last = 1;
            if (early != 0 && $urandom_range(3, 0) == 0) bad_id = 1;
            txn({$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
